cluster_seq: RTL and testbench
==============================

# cluster_seq

Sequencer for the front-end cluster-mux datapath: captures a 128-strip hit map, repeatedly finds the highest-numbered hit strip, steers the 4-bit window mux to that address, and emits one cluster word per hit group over a valid/ready handshake. After each emitted cluster it clears the consumed strips. It sits between the hit-map register stage and the readout packet builder.

## Interface
- MAX_CLUSTERS, 32: maximum clusters emitted per map; only active with truncation compiled in. Legal range 1..32.
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- load_i  input  1  hit map valid; accepted only when load_ready_o=1
- hits_i  input  128  hit map, bit n = strip n
- load_ready_o  output  1  high in IDLE only
- mux_data_o  output  128  working hit map, drives window mux data input
- mux_sel_o  output  7  window mux select (cluster address)
- mux_pat_i  input  4  window mux output: strips {sel, sel-1, sel-2, sel-3}, zero-padded below strip 0
- cluster_valid_o  output  1  cluster word valid
- cluster_ready_i  input  1  downstream accepts word
- cluster_o  output  10  {address[6:0], next3[2:0]}, next3 = mux_pat_i[2:0]
- cluster_last_o  output  1  qualifies final word of the map
- done_o  output  1  one-cycle pulse at end of map processing
- empty_o  output  1  valid with done_o: map had no hits
- overflow_o  output  1  valid with done_o: map truncated at MAX_CLUSTERS

## Operation
- States: IDLE, FIND, EMIT.
- IDLE: load_ready_o=1. On load_i: mux_data_o<=hits_i, count<=0, go FIND.
- FIND: if mux_data_o==0: pulse done_o; empty_o=1 if count==0; go IDLE. Else mux_sel_o<=index of highest set bit, go EMIT.
- EMIT: cluster_valid_o=1, cluster_o={mux_sel_o, mux_pat_i[2:0]}; held stable until cluster_ready_i.
- cluster_last_o=1 when the map after clearing is zero, or (truncation built) count+1==MAX_CLUSTERS.
- On accept: clear bits mux_sel_o down to max(mux_sel_o-3,0); count<=count+1. If last: pulse done_o next cycle (overflow_o=1 if truncated with bits remaining), go IDLE; else go FIND.
- Address<3: cleared range stops at bit 0; pattern bits below strip 0 are 0 (from the mux).
- load_i outside IDLE ignored; hits_i not sampled.
- count is 6 bits, never wraps (≤32 clusters possible by construction).

## Timing
- Reset values: state IDLE, mux_data_o=0, mux_sel_o=0, count=0, load_ready_o=1, cluster_valid_o=0, cluster_last_o=0, done_o=0, empty_o=0, overflow_o=0.
- Load accepted at edge T0; FIND during T0→T1; first cluster_valid_o high from T1→T2 (latency 2 edges load to first word).
- Zero-stall throughput: one cluster per 2 cycles (EMIT, FIND).
- done_o/empty_o/overflow_o registered, high exactly one cycle; load_ready_o high in that same cycle (state is IDLE).
- mux_sel_o and mux_data_o registered; mux path is combinational into cluster_o.
- rst mid-map: immediate return to IDLE, pending word dropped, no done_o.

## Configuration
- CLUSTER_SEQ_TRUNC_EN defined: per-map count compared to MAX_CLUSTERS; remaining hits discarded at limit, overflow_o reported.
- Undefined: all clusters emitted until map empty; overflow_o tied 0; MAX_CLUSTERS unused.

## Test plan
- hits=0 load -> no cluster_valid_o; done_o and empty_o pulse 2 cycles after load; back to IDLE.
- hits bits {127,125} -> one word {127,3'b010}, last=1, done_o, empty_o=0.
- hits bits {10,3,0}, ready always 1 -> words {10,3'b000} then {3,3'b001} with last, 4-cycle span from first valid.
- Backpressure: hits bit 50, ready low 5 cycles -> cluster_o/valid stable, accepted on ready, done_o next cycle.
- Truncation (macro on, MAX_CLUSTERS=2), hits every 8th strip -> words addr 120, 112; second last=1; done_o with overflow_o=1. Macro off -> 16 words, addresses 120..0.
- rst asserted during EMIT -> outputs at reset values same cycle; subsequent load processes normally.

Source files
------------

// File: rtl/cluster_seq.sv
// cluster_seq: scans a 128-strip hit map top-down, steers the window mux to each cluster and emits one word per cluster.
// Latency: the first word is valid 2 edges after load acceptance; with no stalls the block emits one word every 2 cycles (EMIT, FIND).
// Backpressure: the word is held stable in EMIT while cluster_ready_i is low; load_i is only taken in IDLE.
// Optional build macro CLUSTER_SEQ_TRUNC_EN stops each map at MAX_CLUSTERS words and reports overflow_o.
module cluster_seq #(
  parameter int MAX_CLUSTERS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [127:0] hits_i,
  output logic         load_ready_o,
  output logic [127:0] mux_data_o,
  output logic [6:0]   mux_sel_o,
  input  logic [3:0]   mux_pat_i,
  output logic         cluster_valid_o,
  input  logic         cluster_ready_i,
  output logic [9:0]   cluster_o,
  output logic         cluster_last_o,
  output logic         done_o,
  output logic         empty_o,
  output logic         overflow_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIND = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]   state;
  logic [5:0]   count;
  logic [6:0]   top_idx;
  logic [127:0] clr_mask;
  logic [127:0] remaining;
  logic         at_limit;
  logic         last_word;
  logic         accept;

  // mux_pat_i[3] is strip sel itself. It is always set once a cluster has been found, so it does not go into the word.
  logic unused_pat_top;
  assign unused_pat_top = mux_pat_i[3];

  // Find the highest set strip. The upward scan lets the last hit it sees win.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < 128; i++) begin
      if (mux_data_o[i]) top_idx = 7'(i);
    end
  end

  // Build the consumed window: strips sel down to sel-3, clipped at strip 0.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < 128; i++) begin
      if ((i <= int'(mux_sel_o)) && ((i + 3) >= int'(mux_sel_o))) clr_mask[i] = 1'b1;
    end
  end

  assign remaining = mux_data_o & ~clr_mask;

`ifdef CLUSTER_SEQ_TRUNC_EN
  assign at_limit = (count + 6'd1) == 6'(MAX_CLUSTERS);
`else
  logic [5:0] unused_max_clusters;
  assign unused_max_clusters = 6'(MAX_CLUSTERS);
  assign at_limit            = 1'b0;
`endif

  assign load_ready_o    = (state == S_IDLE);
  assign cluster_valid_o = (state == S_EMIT);
  assign cluster_o       = {mux_sel_o, mux_pat_i[2:0]};
  assign last_word       = (remaining == '0) || at_limit;
  assign cluster_last_o  = cluster_valid_o && last_word;
  assign accept          = cluster_valid_o && cluster_ready_i;

  // Sequencer: capture the map, locate the next cluster, wait for the word to be accepted, then retire its strips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mux_data_o <= '0;
      mux_sel_o  <= '0;
      count      <= '0;
      done_o     <= 1'b0;
      empty_o    <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      empty_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_i) begin
            mux_data_o <= hits_i;
            count      <= '0;
            state      <= S_FIND;
          end
        end
        S_FIND: begin
          if (mux_data_o == '0) begin
            done_o  <= 1'b1;
            empty_o <= (count == 6'd0);
            state   <= S_IDLE;
          end else begin
            mux_sel_o <= top_idx;
            state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (accept) begin
            // When the map is truncated, the hits that were not emitted are dropped here.
            mux_data_o <= at_limit ? '0 : remaining;
            count      <= count + 6'd1;
            if (last_word) begin
              done_o <= 1'b1;
              state  <= S_IDLE;
            end else begin
              state <= S_FIND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CLUSTER_SEQ_TRUNC_EN
  // Flag a map that was cut short while strips were still unread; the flag shares the done_o cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_o <= 1'b0;
    else     overflow_o <= accept && at_limit && (remaining != '0);
  end
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_seq.sv
`timescale 1ns/1ps
module tb_cluster_seq;

`ifdef CLUSTER_SEQ_TRUNC_EN
  localparam int MAXC = 2;
`else
  localparam int MAXC = 32;
`endif

  logic         clk;
  logic         rst;
  logic         load;
  logic [127:0] hits;
  logic         load_ready;
  logic [127:0] mux_data;
  logic [6:0]   mux_sel;
  logic [3:0]   pat;
  logic         valid;
  logic         rdy;
  logic [9:0]   word;
  logic         last;
  logic         done;
  logic         empty;
  logic         ovf;

  cluster_seq #(.MAX_CLUSTERS(MAXC)) dut (
    .clk(clk), .rst(rst), .load_i(load), .hits_i(hits), .load_ready_o(load_ready),
    .mux_data_o(mux_data), .mux_sel_o(mux_sel), .mux_pat_i(pat),
    .cluster_valid_o(valid), .cluster_ready_i(rdy), .cluster_o(word),
    .cluster_last_o(last), .done_o(done), .empty_o(empty), .overflow_o(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window mux model: {sel, sel-1, sel-2, sel-3}, zero below strip 0
  always_comb begin
    pat = 4'b0;
    for (int k = 0; k < 4; k++) begin
      if (int'(mux_sel) >= k) pat[3-k] = mux_data[int'(mux_sel) - k];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [9:0] w; logic l; } wexp_t;
  typedef struct packed { logic e; logic o; } dexp_t;
  wexp_t wq[$];
  dexp_t dq[$];
  wexp_t we;
  dexp_t de;
  int    acc_cyc[$];

  int total = 0;
  int bad   = 0;

  bit         stalled = 0;
  logic [9:0] held_w;
  bit         vld_seen = 0;
  bit         done_seen = 0;
  int         first_vld_cyc = 0;
  int         done_cyc = 0;
  int         load_cyc = 0;

  // Monitor: samples on the falling edge and checks DUT outputs against the scoreboard queues
  always @(negedge clk) begin
    if (rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        total++;
        if (valid !== 1'b1 || word !== held_w) begin
          bad++;
          $display("FAIL stall_hold: valid=%0b word=%h required valid=1 word=%h", valid, word, held_w);
        end
      end
      stalled = valid && !rdy;
      held_w  = word;
      if (valid && !vld_seen) begin
        vld_seen      = 1;
        first_vld_cyc = cyc;
      end
      if (valid && rdy) begin
        acc_cyc.push_back(cyc);
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h last=%0b required no word", word, last);
        end else begin
          we = wq.pop_front();
          if (word !== we.w || last !== we.l) begin
            bad++;
            $display("FAIL word: got %h last=%0b required %h last=%0b", word, last, we.w, we.l);
          end
        end
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
        total++;
        if (load_ready !== 1'b1) begin
          bad++;
          $display("FAIL done_ready: load_ready=%0b required 1", load_ready);
        end
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: empty=%0b ovf=%0b required no done", empty, ovf);
        end else begin
          de = dq.pop_front();
          if (empty !== de.e || ovf !== de.o) begin
            bad++;
            $display("FAIL done_flags: empty=%0b ovf=%0b required empty=%0b ovf=%0b", empty, ovf, de.e, de.o);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, expv);
    end
  endtask

  task automatic push_w(input logic [6:0] a, input logic [2:0] n3, input logic l);
    wexp_t t;
    t.w = {a, n3};
    t.l = l;
    wq.push_back(t);
  endtask

  task automatic push_d(input logic e, input logic o);
    dexp_t t;
    t.e = e;
    t.o = o;
    dq.push_back(t);
  endtask

  // Called #1 after a rising edge; on return load_cyc holds the acceptance edge
  task automatic do_load(input logic [127:0] h);
    int n = 0;
    while (!load_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    vld_seen  = 0;
    done_seen = 0;
    acc_cyc.delete();
    load = 1'b1;
    hits = h;
    @(posedge clk); #1;
    load     = 1'b0;
    load_cyc = cyc;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done_seen && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    if (!done_seen) begin
      total++; bad++;
      $display("FAIL done_timeout: no done_o within %0d cycles", maxc);
    end
  endtask

  task automatic wait_valid(input int maxc);
    int n = 0;
    while (!vld_seen && n < maxc) begin
      @(posedge clk); #1; n++;
    end
    if (!vld_seen) begin
      total++; bad++;
      $display("FAIL valid_timeout: no cluster_valid_o within %0d cycles", maxc);
    end
  endtask

  logic [127:0] h8;
  logic [127:0] h50;
  int           nwords;
  int           r;

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    hits = '0;
    rdy  = 1'b1;
    @(negedge clk);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    chk("rst_done", done, 0);
    chk("rst_empty", empty, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_mux_data", mux_data, 0);
    chk("rst_mux_sel", mux_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Empty map
    push_d(1'b1, 1'b0);
    do_load('0);
    wait_done(10);
    chk("zero_done_lat", done_cyc, load_cyc + 1);
    chk("zero_no_word", vld_seen, 0);

    // Strips 127 and 125
    push_w(7'd127, 3'b010, 1'b1);
    push_d(1'b0, 1'b0);
    do_load({1'b1, 1'b0, 1'b1, 125'b0});
    wait_done(20);
    chk("two_first_lat", first_vld_cyc, load_cyc + 1);
    chk("two_done_lat", done_cyc, load_cyc + 2);

    // Strips 10, 3, 0 at full throughput
    push_w(7'd10, 3'b000, 1'b0);
    push_w(7'd3, 3'b001, 1'b1);
    push_d(1'b0, 1'b0);
    do_load(128'h409);
    wait_done(20);
    chk("three_first_lat", first_vld_cyc, load_cyc + 1);
    chk("three_gap", (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1, 2);
    chk("three_done_lat", done_cyc, load_cyc + 4);

    // Backpressure on strip 50; a load attempted mid-map must be ignored
    h50 = '0;
    h50[50] = 1'b1;
    rdy = 1'b0;
    push_w(7'd50, 3'b000, 1'b1);
    push_d(1'b0, 1'b0);
    do_load(h50);
    wait_valid(10);
    load = 1'b1;
    hits = '1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("busy_load_ignored", mux_data, h50);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    r   = cyc;
    wait_done(10);
    chk("bp_done_lat", done_cyc, r + 1);

    // Every 8th strip: truncated at MAXC when built with truncation
    h8 = '0;
    for (int k = 0; k < 16; k++) h8[8*k] = 1'b1;
    nwords = (MAXC < 16) ? MAXC : 16;
    for (int k = 0; k < nwords; k++) push_w(7'(120 - 8*k), 3'b000, (k == nwords - 1));
    push_d(1'b0, (MAXC < 16));
    do_load(h8);
    wait_done(200);
    chk("h8_word_count", acc_cyc.size(), nwords);

    // Reset while a word is pending
    h50 = '0;
    h50[90] = 1'b1;
    rdy = 1'b0;
    do_load(h50);
    wait_valid(10);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_load_ready", load_ready, 1);
    chk("mid_rst_mux_data", mux_data, 0);
    chk("mid_rst_mux_sel", mux_sel, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rdy = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("mid_rst_no_done", done_seen, 0);

    // Normal map after the reset
    push_w(7'd10, 3'b000, 1'b0);
    push_w(7'd3, 3'b001, 1'b1);
    push_d(1'b0, 1'b0);
    do_load(128'h409);
    wait_done(20);
    chk("post_rst_done_lat", done_cyc, load_cyc + 4);

    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("word_queue_drained", wq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
